// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device command transmitter with ACK check and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int c_MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int c_MAX   = (c_MAX_A > TIMEOUT_CYCLES) ? c_MAX_A : TIMEOUT_CYCLES;
    localparam int c_CW    = $clog2(c_MAX + 1);

    localparam logic [c_CW-1:0] c_INH_LAST = c_CW'(INHIBIT_CYCLES - 1);
    localparam logic [c_CW-1:0] c_RTS_LAST = c_CW'(RTS_CYCLES - 1);
    localparam logic [c_CW-1:0] c_TO_LAST  = c_CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic [3:0]      r_bitcnt;
    logic [8:0]      r_shreg;
    logic            r_ack;
    logic            r_clk_meta;
    logic            r_clk_s;
    logic            r_clk_prev;
    logic            r_data_meta;
    logic            r_data_s;
    logic            r_tx_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_clk_oe;
    logic            r_data_oe;
    logic            w_fall;

    assign w_fall = r_clk_prev & ~r_clk_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bitcnt    <= '0;
            r_shreg     <= '0;
            r_ack       <= 1'b0;
            r_clk_meta  <= 1'b0;
            r_clk_s     <= 1'b0;
            r_clk_prev  <= 1'b0;
            r_data_meta <= 1'b0;
            r_data_s    <= 1'b0;
            r_tx_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_clk_oe    <= 1'b0;
            r_data_oe   <= 1'b0;
        end else begin
            r_clk_meta  <= ps2_clk_i;
            r_clk_s     <= r_clk_meta;
            r_clk_prev  <= r_clk_s;
            r_data_meta <= ps2_data_i;
            r_data_s    <= r_data_meta;
            r_done      <= 1'b0;
            r_err       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (tx_valid && r_tx_ready) begin
                        // Bit 8 carries odd parity over the command byte.
                        r_shreg    <= {~^tx_data, tx_data};
                        r_cnt      <= '0;
                        r_clk_oe   <= 1'b1;
                        r_data_oe  <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_INHIBIT;
                    end else begin
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end

                S_INHIBIT: begin
                    if (r_cnt == c_INH_LAST) begin
                        r_cnt     <= '0;
                        r_data_oe <= 1'b1;
                        r_state   <= S_RTS;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end

                S_RTS: begin
                    if (r_cnt == c_RTS_LAST) begin
                        r_cnt    <= '0;
                        r_bitcnt <= '0;
                        r_clk_oe <= 1'b0;
                        r_state  <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end

                S_SEND: begin
                    if (r_cnt == c_TO_LAST) begin
                        r_data_oe <= 1'b0;
                        r_err     <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                        if (w_fall) begin
                            // Device samples on its rising edge, so update right after each fall.
                            if (r_bitcnt <= 4'd8) begin
                                r_data_oe <= ~r_shreg[r_bitcnt];
                            end else if (r_bitcnt == 4'd9) begin
                                r_data_oe <= 1'b0;
                            end else begin
                                r_ack   <= ~r_data_s;
                                r_state <= S_WAIT_IDLE;
                            end
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (r_cnt == c_TO_LAST) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                        if (r_clk_s && r_data_s) begin
                            r_done  <= r_ack;
                            r_err   <= ~r_ack;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = r_tx_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Scoreboard bench for ps2_host_tx with a PS/2 device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int c_INH = 8;
    localparam int c_RTS = 4;
    localparam int c_TO  = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(c_INH),
        .RTS_CYCLES    (c_RTS),
        .TIMEOUT_CYCLES(c_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    typedef struct {
        logic [7:0] b;
        bit         ack_ok;
        bit         has_frame;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] dev_q[$];
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          dev_mode = 0;   // 0 = ACK, 1 = no ACK, 2 = never clocks
    int          dev_k = 0;
    bit          dev_run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // Frame as the device sees it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        int  ones;
        logic par;
        ones = $countones(b);
        par  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Device: 4-cycle half period, samples on rising edge, ACK during clock 11.
    initial begin
        int          t;
        int          p;
        int          k;
        logic [10:0] frame;
        t = 0;
        frame = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dev_run = 1'b0;
                dev_clk_low = 1'b0;
                dev_data_low = 1'b0;
                dev_k = 0;
            end else if (!dev_run) begin
                if (!ps2_clk_oe && ps2_data_oe && dev_mode != 2) begin
                    dev_run = 1'b1;
                    t = 0;
                    dev_k = 0;
                    frame = '0;
                    frame[0] = ps2_data_i;
                end
            end else begin
                t++;
                if (t >= 4) begin
                    p = t - 4;
                    k = p / 8 + 1;
                    if (p % 8 == 0) begin
                        dev_clk_low = 1'b1;
                        dev_k = k;
                    end else if (p % 8 == 4) begin
                        dev_clk_low = 1'b0;
                        if (k <= 10) frame[k] = ps2_data_i;
                        if (k == 10 && dev_mode == 0) dev_data_low = 1'b1;
                        if (k == 11) begin
                            dev_data_low = 1'b0;
                            dev_q.push_back(frame);
                            dev_run = 1'b0;
                            dev_k = 0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: every done/err pulse retires one expected transaction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (done || err)) begin
                chk("done_err_exclusive", {31'd0, done && err}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse actual=done%0b_err%0b expected=none", done, err);
                end else begin
                    e = exp_q.pop_front();
                    chk("outcome_done", {31'd0, done}, {31'd0, e.ack_ok});
                    chk("outcome_err", {31'd0, err}, {31'd0, !e.ack_ok});
                    if (e.has_frame) begin
                        if (dev_q.size() == 0) bound_fail("frame_missing");
                        else chk("frame", {21'd0, dev_q.pop_front()}, {21'd0, ref_frame(e.b)});
                    end
                end
                if (done) done_cnt++;
            end
        end
    end

    // Returns right after the accepting posedge, tx_valid still high.
    task automatic send(input logic [7:0] b, input int mode);
        exp_t e;
        int   n;
        dev_mode = mode;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) bound_fail("accept_wait");
        e.b = b;
        e.ack_ok = (mode == 0);
        e.has_frame = (mode != 2);
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && tx_ready && !dev_run) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) bound_fail("idle_wait");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dc;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done_err", {30'd0, done, err}, 32'd0);
        chk("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED with inhibit / RTS timing, plus an ignored 0xAA request mid-send.
        send(8'hED, 0);
        for (int i = 0; i <= c_INH + c_RTS; i++) begin
            @(negedge clk);
            if (i == 0) tx_valid = 1'b0;
            chk("seq_clk_oe", {31'd0, ps2_clk_oe}, {31'd0, i < c_INH + c_RTS});
            chk("seq_data_oe", {31'd0, ps2_data_oe}, {31'd0, i >= c_INH});
        end
        @(negedge clk);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_in_send", {31'd0, busy}, 32'd1);
        tx_valid = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        chk("aa_ignored", {31'd0, busy}, 32'd0);

        // Back-to-back with tx_valid held: second accept only after first done.
        send(8'hF4, 0);
        dc = done_cnt;
        send(8'h00, 0);
        chk("b2b_after_done", done_cnt - dc, 32'd1);
        drop_valid();
        wait_idle();

        // Device never clocks: err exactly TIMEOUT cycles after clock release.
        send(8'($urandom), 2);
        drop_valid();
        n = 0;
        while (ps2_clk_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!err && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, c_TO);
        chk("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        @(negedge clk);
        chk("timeout_tx_ready", {31'd0, tx_ready}, 32'd1);
        wait_idle();

        // Full frame but no ACK.
        send(8'($urandom), 1);
        drop_valid();
        wait_idle();

        // Randomized bytes and ACK behaviour.
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            send(b, int'($urandom_range(0, 1)));
            drop_valid();
            wait_idle();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // Reset in the middle of SEND, after bit 4.
        send(8'($urandom), 0);
        drop_valid();
        n = 0;
        while (dev_k < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) bound_fail("mid_send_wait");
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("midrst_done_err", {30'd0, done, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        send(8'h01, 0);
        drop_valid();
        wait_idle();

        repeat (10) @(negedge clk);
        chk("dev_queue_empty", dev_q.size(), 32'd0);
        chk("exp_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
